// File: rtl/debug_loader_pkg.sv
// Shared constants for the UART program loader: host command bytes, the
// end-of-program word and the 3-bit controller state encoding.
package debug_loader_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LOAD_BYTE  = 3'd1;
    localparam state_t ST_LOAD_WRITE = 3'd2;
    localparam state_t ST_RUN        = 3'd3;
    localparam state_t ST_STEP       = 3'd4;
    localparam state_t ST_SEND_PC    = 3'd5;
    localparam state_t ST_WAIT_TX    = 3'd6;

endpackage

// File: rtl/debug_loader_byte_assembler.sv
// Packs received bytes MSB-first into a word; word_ready_o pulses with the
// final byte, and word_o holds the complete word from the following cycle.
module debug_loader_byte_assembler #(
    parameter int NBITS = 32,
    parameter int DBITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DBITS-1:0] byte_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic [NBITS-1:0] word_o,
    output logic             word_ready_o
);

    localparam int NB = NBITS / DBITS;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [NBITS-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        word_d       = word_q;
        cnt_d        = cnt_q;
        word_ready_o = 1'b0;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (valid_i) begin
            word_d = {word_q[NBITS-DBITS-1:0], byte_i};
            if (cnt_q == CW'(NB - 1)) begin
                word_ready_o = 1'b1;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/debug_loader.sv
// UART program loader and run/step controller in front of the datapath.
// state      | meaning
// IDLE       | waiting for a command byte
// LOAD_BYTE  | collecting instruction bytes
// LOAD_WRITE | one-cycle instruction memory write
// RUN        | datapath enabled until HALT retires
// STEP       | datapath enabled for one cycle
// SEND_PC    | present one PC byte, pulse tx start
// WAIT_TX    | hold the byte until the transmitter is done
module debug_loader
    import debug_loader_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int MEM_SIZE = 1024,
    parameter int DBITS    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DBITS-1:0] i_rx_data,
    input  logic             i_rx_valid,
    output logic [DBITS-1:0] o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_done,
    output logic             o_imem_we,
    output logic [NBITS-1:0] o_imem_addr,
    output logic [NBITS-1:0] o_imem_data,
    output logic             o_dp_enable,
    output logic             o_dp_rst,
    input  logic [NBITS-1:0] i_pc,
    input  logic             i_halt,
    output logic             o_loaded
);

    localparam int NB = NBITS / DBITS;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [NBITS-1:0] ADDR_LIMIT = NBITS'(MEM_SIZE);

    state_t           state_q, state_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [CW-1:0]    tx_idx_q, tx_idx_d;
    logic             loaded_q, loaded_d;
    logic             dp_rst_q, dp_rst_d;

    logic [NBITS-1:0] asm_word;
    logic             asm_ready;
    logic             asm_valid;
    logic             asm_clear;

    logic             is_load, is_run, is_step;
    logic             load_accept;
    logic             word_is_halt;
    logic             addr_in_range;
    logic             last_byte;
    logic [NBITS-1:0] tx_shift;

    assign is_load       = i_rx_valid && (i_rx_data == DBITS'(CMD_LOAD));
    assign is_run        = i_rx_valid && (i_rx_data == DBITS'(CMD_RUN));
    assign is_step       = i_rx_valid && (i_rx_data == DBITS'(CMD_STEP));
    assign load_accept   = (state_q == ST_IDLE) && is_load;
    assign word_is_halt  = (asm_word == NBITS'(HALT_WORD));
    assign addr_in_range = (addr_q < ADDR_LIMIT);
    assign last_byte     = (tx_idx_q == CW'(NB - 1));
    assign tx_shift      = pc_q << (DBITS * tx_idx_q);

    // Bytes only reach the assembler while a load is collecting them.
    assign asm_valid = (state_q == ST_LOAD_BYTE) && i_rx_valid;
    assign asm_clear = load_accept;

    debug_loader_byte_assembler #(
        .NBITS (NBITS),
        .DBITS (DBITS)
    ) u_byte_assembler (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .byte_i       (i_rx_data),
        .valid_i      (asm_valid),
        .clear_i      (asm_clear),
        .word_o       (asm_word),
        .word_ready_o (asm_ready)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (is_load) begin
                    state_d = ST_LOAD_BYTE;
                end else if (is_run && loaded_q) begin
                    state_d = ST_RUN;
                end else if (is_step && loaded_q) begin
                    state_d = ST_STEP;
                end
            end
            ST_LOAD_BYTE: begin
                if (asm_ready) begin
                    state_d = ST_LOAD_WRITE;
                end
            end
            ST_LOAD_WRITE: state_d = word_is_halt ? ST_IDLE : ST_LOAD_BYTE;
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_SEND_PC;
                end
            end
            ST_STEP:    state_d = ST_SEND_PC;
            ST_SEND_PC: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = last_byte ? ST_IDLE : ST_SEND_PC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_imem_we   = 1'b0;
        o_imem_addr = addr_q;
        o_imem_data = '0;
        o_dp_enable = 1'b0;
        o_tx_start  = 1'b0;
        o_tx_data   = '0;
        case (state_q)
            ST_LOAD_WRITE: begin
                o_imem_we   = addr_in_range;
                o_imem_data = asm_word;
            end
            ST_RUN, ST_STEP: o_dp_enable = 1'b1;
            ST_SEND_PC: begin
                o_tx_start = 1'b1;
                o_tx_data  = tx_shift[NBITS-1 -: DBITS];
            end
            ST_WAIT_TX: o_tx_data = tx_shift[NBITS-1 -: DBITS];
            default: ;
        endcase
    end

    assign o_dp_rst = dp_rst_q;
    assign o_loaded = loaded_q;

    always_comb begin
        addr_d   = addr_q;
        loaded_d = loaded_q;
        dp_rst_d = 1'b0;
        pc_d     = pc_q;
        tx_idx_d = tx_idx_q;
        if (load_accept) begin
            addr_d   = '0;
            loaded_d = 1'b0;
            dp_rst_d = 1'b1;
        end
        if (state_q == ST_LOAD_WRITE) begin
            // Past the end of memory the address parks at MEM_SIZE.
            if (addr_in_range) begin
                addr_d = addr_q + 1'b1;
            end
            if (word_is_halt) begin
                loaded_d = 1'b1;
            end
        end
        if (((state_q == ST_RUN) && i_halt) || (state_q == ST_STEP)) begin
            pc_d     = i_pc;
            tx_idx_d = '0;
        end
        if ((state_q == ST_WAIT_TX) && i_tx_done) begin
            tx_idx_d = tx_idx_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q   <= '0;
            loaded_q <= 1'b0;
            dp_rst_q <= 1'b0;
            pc_q     <= '0;
            tx_idx_q <= '0;
        end else begin
            addr_q   <= addr_d;
            loaded_q <= loaded_d;
            dp_rst_q <= dp_rst_d;
            pc_q     <= pc_d;
            tx_idx_q <= tx_idx_d;
        end
    end

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: load, run, step, pre-load command
// rejection, reset abort, command filtering during RUN and address saturation.
module tb_debug_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        dp_en;
    logic        dp_rst;
    logic [31:0] pc;
    logic        halt;
    logic        loaded;

    int checks = 0;
    int errors = 0;

    int n_dprst = 0;
    int n_we = 0;
    int n_en = 0;
    int n_tx = 0;
    int n_overlap = 0;
    logic [31:0] wa [16];
    logic [31:0] wd [16];
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    always #5 clk = ~clk;

    debug_loader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_done   (tx_done),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_data (imem_data),
        .o_dp_enable (dp_en),
        .o_dp_rst    (dp_rst),
        .i_pc        (pc),
        .i_halt      (halt),
        .o_loaded    (loaded)
    );

    always @(negedge clk) begin
        if (dp_rst) n_dprst++;
        if (dp_en) n_en++;
        if (tx_start) n_tx++;
        if (dp_en && imem_we) n_overlap++;
        if (imem_we) begin
            if (n_we < 16) begin
                wa[n_we] = imem_addr;
                wd[n_we] = imem_data;
            end
            last_wa = imem_addr;
            last_wd = imem_data;
            n_we++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
        tick(1);
    endtask

    task automatic dump_pc(input string tag, input logic [31:0] p);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            int   waited = 0;
            logic seen = 1'b0;
            b = p[31-8*k -: 8];
            while (!seen && waited < 50) begin
                @(negedge clk);
                if (tx_start) seen = 1'b1;
                else waited++;
            end
            check({tag, "_start_seen"}, {31'b0, seen}, 32'd1);
            check({tag, "_byte"}, {24'b0, tx_data}, {24'b0, b});
            @(posedge clk);
            #1;
            repeat (2) begin
                @(negedge clk);
                check({tag, "_hold"}, {23'b0, tx_start, tx_data}, {23'b0, 1'b0, b});
                @(posedge clk);
                #1;
            end
            tx_done = 1'b1;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
        end
    endtask

    initial begin
        int dp0, we0, en0, tx0;
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dp0, we0, en0, tx0;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_done = 1'b0; pc = '0; halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {27'b0, imem_we, dp_en, dp_rst, tx_start, loaded}, 32'd0);
        check("reset_tx_data", {24'b0, tx_data}, 32'd0);
        check("reset_imem_addr", imem_addr, 32'd0);
        check("reset_imem_data", imem_data, 32'd0);
        rst = 1'b0;
        tick(1);

        // Test 4: commands before any load
        en0 = n_en; tx0 = n_tx; dp0 = n_dprst;
        send_byte(8'h52); tick(1);
        send_byte(8'h53); tick(1);
        send_byte(8'h41); tick(3);
        check("preload_en", n_en - en0, 0);
        check("preload_tx", n_tx - tx0, 0);
        check("preload_dprst", n_dprst - dp0, 0);
        check("preload_loaded", {31'b0, loaded}, 32'd0);

        // Test 1: load three words
        dp0 = n_dprst; we0 = n_we;
        send_byte(8'h4C);
        send_word(32'h0000_0001);
        check("load_loaded_mid", {31'b0, loaded}, 32'd0);
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        tick(1);
        check("load_dprst", n_dprst - dp0, 1);
        check("load_we_count", n_we - we0, 3);
        check("load_addr0", wa[0], 32'd0);
        check("load_data0", wd[0], 32'h0000_0001);
        check("load_addr1", wa[1], 32'd1);
        check("load_data1", wd[1], 32'h1234_5678);
        check("load_addr2", wa[2], 32'd2);
        check("load_data2", wd[2], 32'hFFFF_FFFF);
        check("load_loaded", {31'b0, loaded}, 32'd1);

        // Test 2: run until halt after 6 enabled cycles
        pc = 32'h0000_0007;
        en0 = n_en; tx0 = n_tx;
        send_byte(8'h52);
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) halt = 1'b1;
            @(posedge clk);
            #1;
        end
        halt = 1'b0;
        check("run_en_cycles", n_en - en0, 6);
        check("run_en_off", {31'b0, dp_en}, 32'd0);
        dump_pc("run_pc", 32'h0000_0007);
        tick(3);
        check("run_tx_count", n_tx - tx0, 4);
        check("run_en_total", n_en - en0, 6);

        // Test 3: single step
        pc = 32'h0000_00A3;
        en0 = n_en; tx0 = n_tx;
        send_byte(8'h53);
        dump_pc("step_pc", 32'h0000_00A3);
        tick(3);
        check("step_en_cycles", n_en - en0, 1);
        check("step_tx_count", n_tx - tx0, 4);

        // Test 6: command bytes arriving during RUN
        pc = 32'h0000_0055;
        en0 = n_en; tx0 = n_tx; dp0 = n_dprst; we0 = n_we;
        send_byte(8'h52);
        send_byte(8'h4C); tick(1);
        send_byte(8'h53); tick(1);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        dump_pc("runrx_pc", 32'h0000_0055);
        tick(3);
        check("runrx_en_cycles", n_en - en0, 5);
        check("runrx_dprst", n_dprst - dp0, 0);
        check("runrx_tx_count", n_tx - tx0, 4);
        check("runrx_we", n_we - we0, 0);
        check("runrx_loaded", {31'b0, loaded}, 32'd1);

        // Test 5: reset in the middle of a load
        dp0 = n_dprst; we0 = n_we;
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        tick(2);
        check("abort_loaded", {31'b0, loaded}, 32'd0);
        rst = 1'b0;
        tick(1);
        send_byte(8'h4C);
        send_word(32'hFFFF_FFFF);
        tick(1);
        check("abort_we_count", n_we - we0, 1);
        check("abort_addr", wa[we0], 32'd0);
        check("abort_data", wd[we0], 32'hFFFF_FFFF);
        check("abort_dprst", n_dprst - dp0, 2);
        check("abort_loaded_after", {31'b0, loaded}, 32'd1);

        // Address saturation: 1025 ordinary words then HALT
        we0 = n_we;
        send_byte(8'h4C);
        check("sat_loaded_cleared", {31'b0, loaded}, 32'd0);
        for (int i = 0; i < 1025; i++) send_word(32'(i) + 32'h100);
        send_word(32'hFFFF_FFFF);
        tick(1);
        check("sat_we_count", n_we - we0, 1024);
        check("sat_last_addr", last_wa, 32'd1023);
        check("sat_last_data", last_wd, 32'h0000_04FF);
        check("sat_loaded", {31'b0, loaded}, 32'd1);

        check("no_en_we_overlap", n_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
